load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 93 +++++++++
 rtl/load_store_unit_load_align.sv | 30 +++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding, access-size decode and store-side lane helpers.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Undefined codes fall back to a full word access.
    function automatic lsu_size_t access_size(input logic write, input logic [2:0] funct3);
        lsu_size_t sz;
        sz = SZ_WORD;
        if (write) begin
            case ({1'b0, funct3[1:0]})
                SB:      sz = SZ_BYTE;
                SH:      sz = SZ_HALF;
                SW:      sz = SZ_WORD;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                LB, LBU: sz = SZ_BYTE;
                LH, LHU: sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [1:0] natural_lo(input lsu_size_t sz, input logic [1:0] lo);
        logic [1:0] r;
        case (sz)
            SZ_HALF: r = {lo[1], 1'b0};
            SZ_WORD: r = 2'b00;
            default: r = lo;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_enables(input logic write, input lsu_size_t sz,
                                                input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b1111;
        if (write) begin
            case (sz)
                SZ_BYTE: be = 4'b0001 << lo;
                SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] store_data(input lsu_size_t sz, input logic [31:0] wdata);
        logic [31:0] d;
        case (sz)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load-data extraction: picks the addressed byte/halfword lane
// from the memory word and sign- or zero-extends it per funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr, 3'b000} +: 8];
    assign w_half = i_word[{i_addr[1], 4'b0000} +: 16];

    always_comb begin
        o_result = i_word;
        case (i_funct3)
            LB:      o_result = {{24{w_byte[7]}}, w_byte};
            LBU:     o_result = {24'b0, w_byte};
            LH:      o_result = {{16{w_half[15]}}, w_half};
            LHU:     o_result = {16'b0, w_half};
            LW:      o_result = i_word;
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit with a fixed-latency memory port.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of aligning them.
//
// state  | meaning
// IDLE   | ready for a request; req_ready high
// ACCESS | memory strobes driven for one cycle
// WAIT   | load in flight; counts down until mem_q is valid
// RESP   | one-cycle resp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 2
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byteena,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q
);

    lsu_state_t  r_state;
    logic [1:0]  r_cnt;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;

    logic        w_accept;
    lsu_size_t   w_size;
    logic [1:0]  w_addr_lo;
    logic [31:0] w_load_result;

`ifdef LSU_MISALIGN_TRAP_EN
    logic        r_misaligned;
    logic        w_misaligned;

    assign w_misaligned    = is_misaligned(w_size, req_addr[1:0]);
    assign resp_misaligned = r_misaligned;
`else
    assign resp_misaligned = 1'b0;
`endif

    // Reset gates ready so nothing is accepted in the reset cycle itself.
    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_size    = access_size(req_write, req_funct3);
    assign w_addr_lo = natural_lo(w_size, req_addr[1:0]);

    load_align u_load_align (
        .i_word   (mem_q),
        .i_addr   (r_addr_lo),
        .i_funct3 (r_funct3),
        .o_result (w_load_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_write     <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            mem_address <= 32'h0;
            mem_byteena <= 4'b0000;
            mem_data    <= 32'h0;
            mem_wren    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write   <= req_write;
                        r_funct3  <= req_funct3;
                        r_addr_lo <= w_addr_lo;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_state      <= RESP;
                            resp_valid   <= 1'b1;
                            resp_rdata   <= 32'h0;
                            r_misaligned <= 1'b1;
                        end else
`endif
                        begin
                            r_state     <= ACCESS;
                            mem_address <= {2'b00, req_addr[31:2]};
                            mem_byteena <= byte_enables(req_write, w_size, w_addr_lo);
                            mem_data    <= store_data(w_size, req_wdata);
                            mem_wren    <= req_write;
                        end
                    end
                end
                ACCESS: begin
                    mem_wren    <= 1'b0;
                    mem_byteena <= 4'b0000;
                    if (r_write) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= 2'(READ_LATENCY - 1);
                    end
                end
                WAIT: begin
                    // Terminal count lands on the cycle mem_q is valid.
                    if (r_cnt == 2'd0) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= w_load_result;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                    r_misaligned <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and random loads/stores
// against a byte-addressed reference memory, reset abort, back-to-back issue.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int RL = 2;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_address;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    always #5 clock = ~clock;

    load_store_unit #(.READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0]  ref_mem  [0:63];
    logic [31:0] phys_mem [0:15];
    int          rd_cnt = 0;
    logic [31:0] rd_word = 32'h0;

    typedef struct {
        int          lat;
        int          pulses;
        logic [31:0] rdata;
        logic        mis;
        logic        wren;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic        busy_ready;
        logic        ready_after;
    } obs_t;

    // Memory: writes land on strobes, read data appears RL cycles after ACCESS, junk otherwise.
    always @(negedge clock) begin
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            mem_q  = (rd_cnt == 0) ? rd_word : $urandom;
        end else begin
            mem_q = $urandom;
        end
        if (mem_wren)
            for (int i = 0; i < 4; i++)
                if (mem_byteena[i]) phys_mem[mem_address[3:0]][8*i +: 8] = mem_data[8*i +: 8];
        if (mem_byteena != 4'b0000 && !mem_wren) begin
            rd_word = phys_mem[mem_address[3:0]];
            rd_cnt  = RL;
        end
    end

    function automatic int size_of(input logic w, input logic [2:0] f3);
        if (w) return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int eff_lo(input logic [31:0] a, input int sz);
        int lo = int'(a[5:0]);
        return lo - (lo % sz);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        int sz = size_of(1'b0, f3);
        int e  = eff_lo(a, sz);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[(e + i) % 64]) << (8 * i));
        if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        int sz = size_of(1'b1, f3);
        int e  = eff_lo(a, sz);
        logic [31:0] sh;
        for (int i = 0; i < sz; i++) begin
            sh = d >> (8 * i);
            ref_mem[(e + i) % 64] = sh[7:0];
        end
    endtask

    function automatic logic [3:0] model_be(input logic w, input logic [31:0] a, input logic [2:0] f3);
        int sz = size_of(w, f3);
        if (!w) return 4'hF;
        return 4'(((1 << sz) - 1) << (eff_lo(a, sz) % 4));
    endfunction

    function automatic logic [31:0] model_mdata(input logic [31:0] d, input logic [2:0] f3);
        int sz = size_of(1'b1, f3);
        logic [31:0] r = 32'h0;
        logic [31:0] sh;
        for (int i = 0; i < 4; i++) begin
            sh = d >> (8 * (i % sz));
            r[8*i +: 8] = sh[7:0];
        end
        return r;
    endfunction

    // Drives one request and records what the DUT did; caller sits just after a negedge.
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output obs_t o);
        int n = 0;
        o.lat = 0; o.pulses = 0; o.rdata = '0; o.mis = 1'b0; o.wren = 1'b0; o.be = '0;
        o.maddr = '0; o.mdata = '0; o.busy_ready = 1'b0; o.ready_after = 1'b0;
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        while (!req_ready && n < 20) begin @(negedge clock); #1; n++; end
        @(negedge clock); #1;
        req_valid = 1'b0;
        o.wren = mem_wren; o.be = mem_byteena; o.maddr = mem_address; o.mdata = mem_data;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) begin @(negedge clock); #1; end
            if (resp_valid) begin
                o.pulses++;
                if (o.lat == 0) begin o.lat = k; o.rdata = resp_rdata; o.mis = resp_misaligned; end
            end
            if ((o.lat == 0 || k == o.lat) && req_ready) o.busy_ready = 1'b1;
            if (o.lat != 0 && k == o.lat + 1) o.ready_after = req_ready;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", req_ready); else passed++;
        checks++;
        if ({resp_valid, mem_wren, mem_byteena} !== 6'b0 || resp_rdata !== 32'h0 ||
            mem_address !== 32'h0 || mem_data !== 32'h0 || resp_misaligned !== 1'b0)
            $display("FAIL reset_outputs: got rv=%b wr=%b be=%h a=%h d=%h rd=%h mis=%b expected all zero",
                     resp_valid, mem_wren, mem_byteena, mem_address, mem_data, resp_rdata, resp_misaligned);
        else passed++;
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", req_ready); else passed++;
    endtask

    task automatic test_store_directed();
        obs_t o;
        issue(1'b1, SW, 32'h0000_0010, 32'hDEADBEEF, o);
        model_store(32'h10, SW, 32'hDEADBEEF);
        checks++; if (o.maddr !== 32'h4) $display("FAIL sw_addr: got %h expected 00000004", o.maddr); else passed++;
        checks++; if (o.be !== 4'b1111) $display("FAIL sw_be: got %b expected 1111", o.be); else passed++;
        checks++; if (o.mdata !== 32'hDEADBEEF) $display("FAIL sw_data: got %h expected deadbeef", o.mdata); else passed++;
        checks++; if (o.wren !== 1'b1) $display("FAIL sw_wren: got %b expected 1", o.wren); else passed++;
        checks++; if (o.lat !== 2 || o.pulses !== 1) $display("FAIL sw_resp: got lat %0d pulses %0d expected 2/1", o.lat, o.pulses); else passed++;
        checks++; if (o.rdata !== 32'h0) $display("FAIL sw_rdata: got %h expected 0", o.rdata); else passed++;
        issue(1'b1, SB, 32'h0000_0013, 32'h0000_00A5, o);
        model_store(32'h13, SB, 32'hA5);
        checks++; if (o.be !== 4'b1000) $display("FAIL sb_be: got %b expected 1000", o.be); else passed++;
        checks++; if (o.mdata !== 32'hA5A5A5A5) $display("FAIL sb_data: got %h expected a5a5a5a5", o.mdata); else passed++;
        checks++; if (o.maddr !== 32'h4) $display("FAIL sb_addr: got %h expected 00000004", o.maddr); else passed++;
    endtask

    task automatic test_load_directed();
        obs_t o;
        logic [2:0]  f3s  [4] = '{LB, LBU, LH, LHU};
        logic [31:0] adrs [4] = '{32'h3, 32'h3, 32'h2, 32'h0};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        ref_mem[0] = 8'h01; ref_mem[1] = 8'h7F; ref_mem[2] = 8'hFF; ref_mem[3] = 8'h80;
        phys_mem[0] = 32'h80FF7F01;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'h0, o);
            checks++; if (o.rdata !== exps[i]) $display("FAIL load_dir%0d_data: got %h expected %h", i, o.rdata, exps[i]); else passed++;
            checks++; if (o.lat !== 2 + RL) $display("FAIL load_dir%0d_lat: got %0d expected %0d", i, o.lat, 2 + RL); else passed++;
            checks++; if (o.wren !== 1'b0 || o.be !== 4'hF) $display("FAIL load_dir%0d_strobe: got wr %b be %b expected 0/1111", i, o.wren, o.be); else passed++;
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        logic [31:0] exp_rd;
        exp_rd = model_load(32'h6, LW);
        issue(1'b0, LW, 32'h6, 32'h0, o);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (o.lat !== 1) $display("FAIL mis_lat: got %0d expected 1", o.lat); else passed++;
        checks++; if (o.wren !== 1'b0 || o.be !== 4'b0) $display("FAIL mis_strobe: got wr %b be %b expected 0/0000", o.wren, o.be); else passed++;
        checks++; if (o.mis !== 1'b1) $display("FAIL mis_flag: got %b expected 1", o.mis); else passed++;
        checks++; if (o.rdata !== 32'h0) $display("FAIL mis_rdata: got %h expected 0", o.rdata); else passed++;
`else
        checks++; if (o.maddr !== 32'h1) $display("FAIL mis_addr: got %h expected 00000001", o.maddr); else passed++;
        checks++; if (o.lat !== 2 + RL) $display("FAIL mis_lat: got %0d expected %0d", o.lat, 2 + RL); else passed++;
        checks++; if (o.mis !== 1'b0) $display("FAIL mis_flag: got %b expected 0", o.mis); else passed++;
        checks++; if (o.rdata !== exp_rd) $display("FAIL mis_rdata: got %h expected %h", o.rdata, exp_rd); else passed++;
`endif
    endtask

    task automatic test_random();
        obs_t o;
        logic w, trap_hit;
        logic [2:0] f3;
        logic [31:0] a, d, exp_rd;
        int sz, exp_lat;
        for (int t = 0; t < 40; t++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            d  = $urandom;
            sz = size_of(w, f3);
            trap_hit = TRAP_EN && ((int'(a[1:0]) % sz) != 0);
            exp_rd  = (w || trap_hit) ? 32'h0 : model_load(a, f3);
            exp_lat = trap_hit ? 1 : (w ? 2 : 2 + RL);
            issue(w, f3, a, d, o);
            if (w && !trap_hit) model_store(a, f3, d);
            checks++; if (o.lat !== exp_lat || o.pulses !== 1) $display("FAIL rnd%0d_lat: got %0d/%0d expected %0d/1", t, o.lat, o.pulses, exp_lat); else passed++;
            checks++; if (o.rdata !== exp_rd) $display("FAIL rnd%0d_rdata: got %h expected %h (w=%b f3=%0d a=%h)", t, o.rdata, exp_rd, w, f3, a); else passed++;
            checks++; if (o.mis !== trap_hit) $display("FAIL rnd%0d_mis: got %b expected %b", t, o.mis, trap_hit); else passed++;
            checks++; if (o.busy_ready !== 1'b0 || o.ready_after !== 1'b1) $display("FAIL rnd%0d_ready: got busy %b after %b expected 0/1", t, o.busy_ready, o.ready_after); else passed++;
            if (!trap_hit) begin
                checks++; if (o.wren !== w || o.be !== model_be(w, a, f3)) $display("FAIL rnd%0d_strobe: got wr %b be %b expected %b/%b", t, o.wren, o.be, w, model_be(w, a, f3)); else passed++;
                checks++; if (o.maddr !== (a >> 2)) $display("FAIL rnd%0d_addr: got %h expected %h", t, o.maddr, a >> 2); else passed++;
            end
            if (w && !trap_hit) begin
                checks++; if (o.mdata !== model_mdata(d, f3)) $display("FAIL rnd%0d_mdata: got %h expected %h", t, o.mdata, model_mdata(d, f3)); else passed++;
            end
        end
    endtask

    task automatic test_reset_during_wait();
        obs_t o;
        int n = 0;
        int pulses = 0;
        logic [31:0] exp_rd;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = LW; req_addr = 32'h8; req_wdata = 32'h0;
        while (!req_ready && n < 20) begin @(negedge clock); #1; n++; end
        @(negedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL rst_wait_ready_in_reset: got %b expected 0", req_ready); else passed++;
        @(negedge clock); #1;
        checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || mem_address !== 32'h0) $display("FAIL rst_wait_cleared: got rv %b rd %h a %h expected 0", resp_valid, resp_rdata, mem_address); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_wait_ready_after: got %b expected 1", req_ready); else passed++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock); #1;
            if (resp_valid) pulses++;
        end
        checks++; if (pulses !== 0) $display("FAIL rst_wait_no_resp: got %0d pulses expected 0", pulses); else passed++;
        exp_rd = model_load(32'h8, LW);
        issue(1'b0, LW, 32'h8, 32'h0, o);
        checks++; if (o.rdata !== exp_rd || o.lat !== 2 + RL) $display("FAIL rst_wait_recover: got %h lat %0d expected %h lat %0d", o.rdata, o.lat, exp_rd, 2 + RL); else passed++;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int first_ready = 0;
        int r1 = 0;
        int r2 = 0;
        logic busy = 1'b0;
        logic [31:0] d2 = 32'h1234_5678;
        logic [31:0] data2 = 32'h0;
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = SW; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        while (!req_ready && n < 20) begin @(negedge clock); #1; n++; end
        @(negedge clock); #1;
        req_addr = 32'h24; req_wdata = d2;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin @(negedge clock); #1; end
            if (resp_valid) begin if (r1 == 0) r1 = k; else if (r2 == 0) r2 = k; end
            if (k == 4) begin req_valid = 1'b0; data2 = mem_data; end
            if (req_ready && first_ready == 0) first_ready = k;
            if (k <= 2 && req_ready) busy = 1'b1;
        end
        model_store(32'h20, SW, 32'hCAFE_F00D);
        model_store(32'h24, SW, d2);
        checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_ready: got %b expected 0", busy); else passed++;
        checks++; if (first_ready !== 3) $display("FAIL b2b_second_accept: got cycle %0d expected 3", first_ready); else passed++;
        checks++; if (r1 !== 2 || r2 !== 5) $display("FAIL b2b_resp: got %0d,%0d expected 2,5", r1, r2); else passed++;
        checks++; if (data2 !== d2) $display("FAIL b2b_data2: got %h expected %h", data2, d2); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++)
            phys_mem[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        test_reset();
        @(negedge clock); #1;
        test_store_directed();
        test_load_directed();
        test_misaligned();
        test_random();
        test_reset_during_wait();
        test_back_to_back();
        repeat (4) @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1);
    end

endmodule
